// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the clock/reset fabric around it.
// The master drives the lock flags and firmware requests; the slave is the supervisor itself.
interface pll_lock_supervisor_if #(
  parameter int NUM_PLLS    = 2,
  parameter int COUNT_WIDTH = 16
);
  logic [NUM_PLLS-1:0]    pll_lock;
  logic                   force_reset;
  logic                   clear_counters;
  logic                   pll_reset;
  logic                   sys_rst;
  logic [NUM_PLLS-1:0]    all_locked;
  logic [NUM_PLLS-1:0]    lost_mask;
  logic [COUNT_WIDTH-1:0] loss_count;
  logic [COUNT_WIDTH-1:0] timeout_count;

  modport master (
    output pll_lock, force_reset, clear_counters,
    input  pll_reset, sys_rst, all_locked, lost_mask, loss_count, timeout_count
  );

  modport slave (
    input  pll_lock, force_reset, clear_counters,
    output pll_reset, sys_rst, all_locked, lost_mask, loss_count, timeout_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock debounce and downstream reset release; tracks lock loss and
// lock-acquire timeouts with saturating counters. Runs on the free-running input clock.
module pll_lock_supervisor #(
  parameter int NUM_PLLS        = 2,
  parameter int PLL_RESET_PULSE = 16,
  parameter int LOCK_TIMEOUT    = 125000,
  parameter int LOCK_DEBOUNCE   = 1024,
  parameter int RESET_HOLD      = 256,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_lock_supervisor_if.slave  bus
);

  localparam int MAX_AB      = (PLL_RESET_PULSE > LOCK_TIMEOUT) ? PLL_RESET_PULSE : LOCK_TIMEOUT;
  localparam int MAX_CD      = (LOCK_DEBOUNCE > RESET_HOLD) ? LOCK_DEBOUNCE : RESET_HOLD;
  localparam int TIMER_MAX   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TIMER_WIDTH = $clog2(TIMER_MAX);

  localparam logic [TIMER_WIDTH-1:0] PULSE_LAST    = TIMER_WIDTH'(PLL_RESET_PULSE - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST  = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] DEBOUNCE_LAST = TIMER_WIDTH'(LOCK_DEBOUNCE - 1);
  localparam logic [TIMER_WIDTH-1:0] HOLD_LAST     = TIMER_WIDTH'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    DEBOUNCE,
    HOLD,
    RUN
  } state_e;

  state_e                 state;
  logic [TIMER_WIDTH-1:0] timer;
  logic [NUM_PLLS-1:0]    sync_meta;
  logic [NUM_PLLS-1:0]    sync_lock;
  logic [NUM_PLLS-1:0]    lost_mask;
  logic [COUNT_WIDTH-1:0] loss_count;
  logic [COUNT_WIDTH-1:0] timeout_count;

  logic                   locked;
  logic [COUNT_WIDTH-1:0] loss_base;
  logic [COUNT_WIDTH-1:0] timeout_base;
  logic [NUM_PLLS-1:0]    mask_base;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
    return (&value) ? value : value + COUNT_WIDTH'(1);
  endfunction

  // A same-cycle clear takes effect before any increment or OR on top of it.
  assign locked       = &sync_lock;
  assign loss_base    = bus.clear_counters ? '0 : loss_count;
  assign timeout_base = bus.clear_counters ? '0 : timeout_count;
  assign mask_base    = bus.clear_counters ? '0 : lost_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PLL_RST;
      timer         <= '0;
      sync_meta     <= '0;
      sync_lock     <= '0;
      lost_mask     <= '0;
      loss_count    <= '0;
      timeout_count <= '0;
    end else begin
      sync_meta <= bus.pll_lock;
      sync_lock <= sync_meta;

      // NOTE: non-blocking defaults here are overridden by later assignments in the same
      // block; the last scheduled update to a register wins, so event paths need no else.
      loss_count    <= loss_base;
      timeout_count <= timeout_base;
      lost_mask     <= mask_base;

      if (bus.force_reset) begin
        state <= PLL_RST;
        timer <= '0;
      end else begin
        case (state)
          PLL_RST: begin
            if (timer == PULSE_LAST) begin
              state <= WAIT_LOCK;
              timer <= '0;
            end else begin
              timer <= timer + TIMER_WIDTH'(1);
            end
          end

          WAIT_LOCK: begin
            if (locked) begin
              state <= DEBOUNCE;
              timer <= '0;
            end else if (timer == TIMEOUT_LAST) begin
              state         <= PLL_RST;
              timer         <= '0;
              timeout_count <= sat_inc(timeout_base);
            end else begin
              timer <= timer + TIMER_WIDTH'(1);
            end
          end

          // Glitches here fall back silently and restart the timeout window.
          DEBOUNCE: begin
            if (!locked) begin
              state <= WAIT_LOCK;
              timer <= '0;
            end else if (timer == DEBOUNCE_LAST) begin
              state <= HOLD;
              timer <= '0;
            end else begin
              timer <= timer + TIMER_WIDTH'(1);
            end
          end

          HOLD: begin
            if (!locked) begin
              state <= WAIT_LOCK;
              timer <= '0;
            end else if (timer == HOLD_LAST) begin
              state <= RUN;
              timer <= '0;
            end else begin
              timer <= timer + TIMER_WIDTH'(1);
            end
          end

          RUN: begin
            if (!locked) begin
              state      <= WAIT_LOCK;
              timer      <= '0;
              loss_count <= sat_inc(loss_base);
              lost_mask  <= mask_base | ~sync_lock;
            end
          end

          default: begin
            state <= PLL_RST;
            timer <= '0;
          end
        endcase
      end
    end
  end

  assign bus.pll_reset     = (state == PLL_RST);
  assign bus.sys_rst       = (state != RUN);
  assign bus.all_locked    = sync_lock;
  assign bus.lost_mask     = lost_mask;
  assign bus.loss_count    = loss_count;
  assign bus.timeout_count = timeout_count;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus randomized lock
// traffic, all compared every cycle against a phase/age reference model.
module tb_pll_lock_supervisor;

  localparam int NUM_PLLS = 2;
  localparam int PULSE    = 4;
  localparam int TIMEOUT  = 32;
  localparam int DEBOUNCE = 8;
  localparam int HOLD     = 4;
  localparam int CW       = 2;
  localparam int CMAX     = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor_if #(.NUM_PLLS(NUM_PLLS), .COUNT_WIDTH(CW)) bus ();

  pll_lock_supervisor #(
    .NUM_PLLS(NUM_PLLS), .PLL_RESET_PULSE(PULSE), .LOCK_TIMEOUT(TIMEOUT),
    .LOCK_DEBOUNCE(DEBOUNCE), .RESET_HOLD(HOLD), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: named phase plus cycles spent in it, lock history as a queue.
  typedef enum {M_KICK, M_WAIT, M_DEB, M_HOLD, M_RUN} phase_e;
  phase_e     m_phase = M_KICK;
  int         m_age   = 0;
  int         m_loss  = 0;
  int         m_to    = 0;
  logic [1:0] m_mask  = '0;
  logic [1:0] m_hist[$];

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic int phase_len(input phase_e p);
    case (p)
      M_KICK:  return PULSE;
      M_WAIT:  return TIMEOUT;
      M_DEB:   return DEBOUNCE;
      M_HOLD:  return HOLD;
      default: return 0;
    endcase
  endfunction

  task automatic enter(input phase_e p);
    m_phase = p;
    m_age   = 0;
  endtask

  task automatic model_step();
    logic [1:0] seen;
    bit         ok;
    if (rst) begin
      enter(M_KICK);
      m_loss = 0;
      m_to   = 0;
      m_mask = '0;
      m_hist.delete();
      m_hist.push_back(2'b00);
      m_hist.push_back(2'b00);
      return;
    end
    seen = m_hist[0];
    ok   = (seen == 2'b11);
    void'(m_hist.pop_front());
    m_hist.push_back(bus.pll_lock);
    if (bus.clear_counters) begin
      m_loss = 0;
      m_to   = 0;
      m_mask = '0;
    end
    if (bus.force_reset) begin
      enter(M_KICK);
    end else begin
      case (m_phase)
        M_KICK: if (m_age + 1 == phase_len(M_KICK)) enter(M_WAIT); else m_age++;
        M_WAIT: begin
          if (ok) enter(M_DEB);
          else if (m_age + 1 == phase_len(M_WAIT)) begin
            enter(M_KICK);
            m_to = sat(m_to + 1);
          end else m_age++;
        end
        M_DEB, M_HOLD: begin
          if (!ok) enter(M_WAIT);
          else if (m_age + 1 == phase_len(m_phase)) enter(m_phase == M_DEB ? M_HOLD : M_RUN);
          else m_age++;
        end
        default: begin
          if (!ok) begin
            enter(M_WAIT);
            m_loss = sat(m_loss + 1);
            m_mask = m_mask | ~seen;
          end
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic compare_model();
    check("pll_reset",     32'(bus.pll_reset),     32'(m_phase == M_KICK));
    check("sys_rst",       32'(bus.sys_rst),       32'(m_phase != M_RUN));
    check("all_locked",    32'(bus.all_locked),    32'(m_hist[0]));
    check("lost_mask",     32'(bus.lost_mask),     32'(m_mask));
    check("loss_count",    32'(bus.loss_count),    32'(m_loss));
    check("timeout_count", 32'(bus.timeout_count), 32'(m_to));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare_model();
  endtask

  task automatic do_reset(input logic [1:0] lock);
    rst                = 1'b1;
    bus.pll_lock       = lock;
    bus.force_reset    = 1'b0;
    bus.clear_counters = 1'b0;
    tick();
    tick();
    check("rst_pll_reset",  32'(bus.pll_reset),     32'd1);
    check("rst_sys_rst",    32'(bus.sys_rst),       32'd1);
    check("rst_all_locked", 32'(bus.all_locked),    32'd0);
    check("rst_lost_mask",  32'(bus.lost_mask),     32'd0);
    check("rst_loss",       32'(bus.loss_count),    32'd0);
    check("rst_timeout",    32'(bus.timeout_count), 32'd0);
    rst = 1'b0;
    cyc = 0;
  endtask

  // Ticks until sys_rst equals val or the budget expires; counts pll_reset-high samples.
  task automatic run_until_sys_rst(input string tag, input logic val, input int budget,
                                   output int n, output int kicks);
    n     = 0;
    kicks = 0;
    while (bus.sys_rst !== val && n < budget) begin
      tick();
      n++;
      if (bus.pll_reset) kicks++;
    end
    check(tag, 32'(bus.sys_rst), 32'(val));
  endtask

  initial begin
    int n, kicks, hi, k, t0;
    bit saw_low;
    logic prev;

    // Locked throughout: release at cycle 17, 4-cycle pll_reset pulse.
    do_reset(2'b11);
    hi = int'(bus.pll_reset);
    run_until_sys_rst("lock_reach_run", 1'b0, 40, n, kicks);
    check("lock_fall_cycle", n, 17);
    check("lock_pll_reset_cycles", hi + kicks, 4);
    check("lock_loss", 32'(bus.loss_count), 0);

    // One-cycle glitch on pll_lock[1] during DEBOUNCE.
    do_reset(2'b11);
    repeat (7) tick();
    bus.pll_lock = 2'b01;
    tick();
    bus.pll_lock = 2'b11;
    n = 0;
    while (bus.all_locked == 2'b11 && n < 6) begin tick(); n++; end
    check("glitch_seen", 32'(bus.all_locked != 2'b11), 1);
    n = 0;
    while (bus.all_locked != 2'b11 && n < 6) begin tick(); n++; end
    check("glitch_relock", 32'(bus.all_locked), 32'h3);
    run_until_sys_rst("glitch_reach_run", 1'b0, 40, n, kicks);
    check("glitch_fall_delay", n, DEBOUNCE + HOLD + 1);
    check("glitch_kicks", kicks, 0);
    check("glitch_loss", 32'(bus.loss_count), 0);
    check("glitch_mask", 32'(bus.lost_mask), 0);

    // Never locked: kick every 36 cycles, timeout_count saturates at 3.
    do_reset(2'b00);
    k       = 0;
    saw_low = 1'b0;
    for (int i = 0; i < 150; i++) begin
      prev = bus.pll_reset;
      tick();
      if (!bus.sys_rst) saw_low = 1'b1;
      if (!prev && bus.pll_reset) begin
        check("to_rise_cycle", cyc, (PULSE + TIMEOUT) * (k + 1));
        check("to_count", 32'(bus.timeout_count), sat(k + 1));
        k++;
      end
    end
    check("to_rises", k, 4);
    check("to_sys_rst_low", 32'(saw_low), 0);

    // Lock loss of pll_lock[0] in RUN, then re-lock without a kick.
    do_reset(2'b11);
    run_until_sys_rst("loss_reach_run", 1'b0, 40, n, kicks);
    bus.pll_lock = 2'b10;
    tick();
    tick();
    check("loss_sys_rst_t2", 32'(bus.sys_rst), 0);
    tick();
    check("loss_sys_rst_t3", 32'(bus.sys_rst), 1);
    check("loss_count1", 32'(bus.loss_count), 1);
    check("loss_mask01", 32'(bus.lost_mask), 32'h1);
    bus.pll_lock = 2'b11;
    run_until_sys_rst("loss_relock_run", 1'b0, 40, n, kicks);
    check("loss_relock_delay", n, 2 + DEBOUNCE + HOLD + 1);
    check("loss_relock_kicks", kicks, 0);

    // force_reset in RUN: exactly one 4-cycle pulse starting next cycle.
    bus.force_reset = 1'b1;
    tick();
    bus.force_reset = 1'b0;
    check("force_pll_reset", 32'(bus.pll_reset), 1);
    check("force_sys_rst", 32'(bus.sys_rst), 1);
    hi = 1;
    n  = 0;
    while (bus.pll_reset && n < 10) begin
      tick();
      n++;
      if (bus.pll_reset) hi++;
    end
    check("force_pulse_len", hi, PULSE);
    check("force_loss_kept", 32'(bus.loss_count), 1);

    // clear_counters in the same cycle as a RUN loss of pll_lock[1].
    run_until_sys_rst("clr_reach_run", 1'b0, 60, n, kicks);
    bus.pll_lock = 2'b01;
    tick();
    tick();
    bus.clear_counters = 1'b1;
    tick();
    bus.clear_counters = 1'b0;
    check("clr_loss", 32'(bus.loss_count), 1);
    check("clr_mask", 32'(bus.lost_mask), 32'h2);
    check("clr_sys_rst", 32'(bus.sys_rst), 1);

    // rst asserted mid-HOLD.
    bus.pll_lock = 2'b11;
    n = 0;
    while (m_phase != M_HOLD && n < 40) begin tick(); n++; end
    check("reach_hold", 32'(m_phase == M_HOLD), 1);
    tick();
    rst = 1'b1;
    tick();
    check("hold_rst_pll_reset", 32'(bus.pll_reset), 1);
    check("hold_rst_sys_rst", 32'(bus.sys_rst), 1);
    check("hold_rst_all_locked", 32'(bus.all_locked), 0);
    check("hold_rst_mask", 32'(bus.lost_mask), 0);
    check("hold_rst_loss", 32'(bus.loss_count), 0);
    rst = 1'b0;

    // Randomized lock traffic with sporadic force, clear and reset.
    do_reset(2'b11);
    t0 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (t0 == 0) begin
        bus.pll_lock = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom_range(0, 3));
        t0 = $urandom_range(1, 40);
      end
      t0--;
      bus.force_reset    = ($urandom_range(0, 149) == 0);
      bus.clear_counters = ($urandom_range(0, 59) == 0);
      rst                = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst                = 1'b0;
    bus.force_reset    = 1'b0;
    bus.clear_counters = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumes the PLL lock flags from the clock generation block and produces the design's global synchronous reset (sys_rst) plus the PLL reset request (pll_reset).
- Runs on the free-running buffered 125 MHz input clock, which does not depend on any PLL.
- Holds downstream logic in reset until every PLL has been stably locked for a debounce window, then for a hold window.
- Detects lock loss and lock-acquire timeout, re-kicks the PLLs, and keeps saturating event counters for firmware.

Parameters:
- NUM_PLLS, 2, number of lock inputs monitored.
- PLL_RESET_PULSE, 16, cycles pll_reset is held high per kick (>=1).
- LOCK_TIMEOUT, 125000, cycles allowed in WAIT_LOCK before re-kick (1 ms at 125 MHz, >=2).
- LOCK_DEBOUNCE, 1024, consecutive all-locked cycles required (>=1).
- RESET_HOLD, 256, extra cycles sys_rst is held after debounce (>=1).
- COUNT_WIDTH, 16, width of the loss and timeout counters.

Ports:
- clk, in, 1, free-running 125 MHz clock.
- rst, in, 1, synchronous, active-high.
- pll_lock, in, NUM_PLLS, raw asynchronous lock flags.
- force_reset, in, 1, single-cycle request to re-kick the PLLs.
- clear_counters, in, 1, single-cycle clear of loss_count, timeout_count and lost_mask.
- pll_reset, out, 1, reset to all PLLs.
- sys_rst, out, 1, synchronous active-high reset for downstream logic.
- all_locked, out, NUM_PLLS, synchronized lock flags.
- lost_mask, out, NUM_PLLS, sticky record of which PLLs dropped lock while in RUN.
- loss_count, out, COUNT_WIDTH, saturating count of lock losses in RUN.
- timeout_count, out, COUNT_WIDTH, saturating count of WAIT_LOCK timeouts.

Behaviour:
- Reset values (rst high): state=PLL_RST, timer=0, pll_reset=1, sys_rst=1, all_locked=0, lost_mask=0, loss_count=0, timeout_count=0.
- Synchronizer: each pll_lock bit passes through a 2-FF synchronizer (reset to 0). Output is all_locked. Input-to-all_locked latency is 2 cycles. "locked" means all bits of all_locked are 1.
- Outputs are pure decodes of the state register:
  - pll_reset = (state==PLL_RST).
  - sys_rst = (state!=RUN).
- One shared timer. It clears on every state transition.

State machine:
- PLL_RST: timer counts; at timer==PLL_RESET_PULSE-1 -> WAIT_LOCK. Lasts exactly PLL_RESET_PULSE cycles.
- WAIT_LOCK:
  - If locked -> DEBOUNCE.
  - Else if timer==LOCK_TIMEOUT-1 -> PLL_RST and timeout_count++.
  - Else timer++.
- DEBOUNCE:
  - Any bit low -> WAIT_LOCK, no counter change.
  - Else at timer==LOCK_DEBOUNCE-1 -> HOLD. Lasts LOCK_DEBOUNCE cycles.
- HOLD:
  - Any bit low -> WAIT_LOCK, no counter change.
  - Else at timer==RESET_HOLD-1 -> RUN.
- RUN:
  - Any bit low -> WAIT_LOCK next cycle, loss_count++, lost_mask |= ~all_locked.
  - sys_rst is high again on the following cycle.

Priorities and boundary conditions:
- Priority order is rst > force_reset > normal transitions.
- force_reset in any state -> PLL_RST next cycle with timer=0. It is not counted. force_reset during PLL_RST restarts the pulse.
- Counters saturate at all-ones and never wrap.
- clear_counters is applied before the same-cycle increment, so a simultaneous clear and event leaves the counter at 1. lost_mask is cleared the same way, then the new bits are ORed in.
- A lock glitch during DEBOUNCE or HOLD is silent and restarts the timeout window from 0.
- rst asserted mid-operation returns every register to its reset value on the next edge, regardless of state.

Test Plan:
- Use PLL_RESET_PULSE=4, LOCK_DEBOUNCE=8, RESET_HOLD=4, LOCK_TIMEOUT=32, COUNT_WIDTH=2, with cycle 0 being the first cycle after rst release.
- pll_lock=2'b11 throughout -> pll_reset high cycles 0-3; WAIT_LOCK at 4; DEBOUNCE 5-12; HOLD 13-16; sys_rst falls at cycle 17; counters remain 0.
- pll_lock=2'b00 forever -> pll_reset pulses 4 cycles every 36 cycles; timeout_count reads 1, 2, 3, then stays 3 (saturation); sys_rst never falls.
- pll_lock[1] low for 1 input cycle during DEBOUNCE -> FSM returns to WAIT_LOCK; sys_rst falls 8+4+1 cycles after all_locked is high again; loss_count=0, lost_mask=0.
- In RUN, drop pll_lock[0] at input cycle t -> sys_rst=1 at t+3; loss_count=1; lost_mask=2'b01; re-lock yields RUN after the debounce and hold windows with no pll_reset pulse.
- In RUN, pulse force_reset -> pll_reset high for exactly 4 cycles starting next cycle; sys_rst high; loss_count unchanged.
- clear_counters coincident with a RUN lock loss of pll_lock[1] -> loss_count=1, lost_mask=2'b10. Assert rst mid-HOLD -> all outputs at reset values next cycle.
